// File: rtl/chip_bcr_parameters_pkg.sv
// Shared control-plane output parameters and the source tag type for the merge block.
package chip_bcr_parameters_pkg;

    localparam int TEST_CP_OUT_ADDR_WIDTH = 37;
    localparam int CP_OUT_FIFO_DEPTH      = 4;

    typedef enum logic {
        CP_SRC_A = 1'b0,
        CP_SRC_B = 1'b1
    } cp_out_src_e;

endpackage

// File: rtl/cp_out_fifo.sv
// Purpose: small synchronous FIFO buffering one block's control-plane address stream.
// Latency: a push at edge N is poppable from edge N+1 (no bypass).
// Backpressure: full is derived from the pointers only; pushes while full are ignored.
module cp_out_fifo #(
    parameter int DATA_WIDTH = 37,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    input  logic                  pop,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/chip_cp_out_merge.sv
// Purpose: merges block_a/block_b control-plane address streams round-robin, tagging each beat's source.
// Latency: 2 cycles input-valid to output-valid; 1 beat/cycle sustained.
// Backpressure: x_ready drops when that block's FIFO is full; output beat held while out_valid && !out_ready.
module chip_cp_out_merge
    import chip_bcr_parameters_pkg::*;
#(
    parameter int CP_OUT_ADDR_WIDTH = TEST_CP_OUT_ADDR_WIDTH,
    parameter int FIFO_DEPTH        = CP_OUT_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         a_valid,
    output logic                         a_ready,
    input  logic [CP_OUT_ADDR_WIDTH-1:0] a_addr,
    input  logic                         b_valid,
    output logic                         b_ready,
    input  logic [CP_OUT_ADDR_WIDTH-1:0] b_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CP_OUT_ADDR_WIDTH-1:0] out_addr,
    output logic                         out_src
);

    logic                         a_full;
    logic                         a_empty;
    logic [CP_OUT_ADDR_WIDTH-1:0] a_rdata;
    logic                         b_full;
    logic                         b_empty;
    logic [CP_OUT_ADDR_WIDTH-1:0] b_rdata;

    logic                         load;
    logic                         a_pop;
    logic                         b_pop;
    cp_out_src_e                  grant;
    cp_out_src_e                  last_grant;

    assign a_ready = !a_full;
    assign b_ready = !b_full;

    cp_out_fifo #(
        .DATA_WIDTH (CP_OUT_ADDR_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_a_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (a_valid),
        .wdata (a_addr),
        .full  (a_full),
        .pop   (a_pop),
        .empty (a_empty),
        .rdata (a_rdata)
    );

    cp_out_fifo #(
        .DATA_WIDTH (CP_OUT_ADDR_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_b_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (b_valid),
        .wdata (b_addr),
        .full  (b_full),
        .pop   (b_pop),
        .empty (b_empty),
        .rdata (b_rdata)
    );

    // On a tie the source that did not win last time is granted.
    always_comb begin
        grant = CP_SRC_A;
        if (!b_empty && (a_empty || last_grant == CP_SRC_A)) begin
            grant = CP_SRC_B;
        end
    end

    assign load  = (!out_valid || out_ready) && !(a_empty && b_empty);
    assign a_pop = load && (grant == CP_SRC_A);
    assign b_pop = load && (grant == CP_SRC_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_src    <= 1'b0;
            last_grant <= CP_SRC_B;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_addr   <= (grant == CP_SRC_B) ? b_rdata : a_rdata;
            out_src    <= grant;
            last_grant <= grant;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_chip_cp_out_merge.sv
// Directed and randomized bench for chip_cp_out_merge against a queue-based reference model.
module tb_chip_cp_out_merge;

    localparam int W     = 37;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         a_valid = 1'b0;
    logic         a_ready;
    logic [W-1:0] a_addr = '0;
    logic         b_valid = 1'b0;
    logic         b_ready;
    logic [W-1:0] b_addr = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_addr;
    logic         out_src;

    int checks = 0;
    int errors = 0;

    chip_cp_out_merge #(
        .CP_OUT_ADDR_WIDTH (W),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Reference model: per-source queues plus one output slot.
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    bit           m_valid = 1'b0;
    logic [W-1:0] m_addr  = '0;
    bit           m_src   = 1'b0;
    bit           m_last  = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        bit a_acc;
        bit b_acc;
        bit pick_b;
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            m_valid = 1'b0;
            m_addr  = '0;
            m_src   = 1'b0;
            m_last  = 1'b1;
        end else begin
            a_acc = a_valid && (qa.size() < DEPTH);
            b_acc = b_valid && (qb.size() < DEPTH);
            if ((!m_valid || out_ready) && (qa.size() > 0 || qb.size() > 0)) begin
                if (qa.size() > 0 && qb.size() > 0) pick_b = !m_last;
                else                                pick_b = (qb.size() > 0);
                m_addr  = pick_b ? qb.pop_front() : qa.pop_front();
                m_src   = pick_b;
                m_valid = 1'b1;
                m_last  = pick_b;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (a_acc) qa.push_back(a_addr);
            if (b_acc) qb.push_back(b_addr);
        end
    end

    always @(negedge clk) begin
        chk("mdl_a_ready", a_ready, qa.size() < DEPTH);
        chk("mdl_b_ready", b_ready, qb.size() < DEPTH);
        chk("mdl_out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("mdl_out_addr", out_addr, m_addr);
            chk("mdl_out_src", out_src, m_src);
        end
    end

    initial begin
        logic [63:0] r;

        // Reset with a_valid high
        a_valid = 1'b1;
        a_addr  = 37'h55;
        tick; tick; tick;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_b_ready", b_ready, 1);
        rst_n = 1'b1;
        tick;
        a_valid = 1'b0;
        chk("lat_e1_valid", out_valid, 0);
        tick;
        chk("lat_e2_valid", out_valid, 1);
        chk("lat_e2_addr", out_addr, 37'h55);
        tick;
        chk("lat_drain", out_valid, 0);

        // Single source, back-to-back
        for (int i = 1; i <= 8; i++) begin
            a_valid = 1'b1;
            a_addr  = W'(i);
            tick;
            if (i >= 2) begin
                chk("single_addr", out_addr, i - 1);
                chk("single_src", out_src, 0);
            end
        end
        a_valid = 1'b0;
        tick;
        chk("single_last", out_addr, 8);
        tick;
        chk("single_idle", out_valid, 0);

        // Tie arbitration after a fresh reset
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        a_valid = 1'b1; a_addr = 37'hA0;
        b_valid = 1'b1; b_addr = 37'hB0;
        tick;
        a_addr = 37'hA1;
        b_addr = 37'hB1;
        tick;
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("tie_0", {out_src, out_addr}, {1'b0, 37'hA0});
        tick;
        chk("tie_1", {out_src, out_addr}, {1'b1, 37'hB0});
        tick;
        chk("tie_2", {out_src, out_addr}, {1'b0, 37'hA1});
        tick;
        chk("tie_3", {out_src, out_addr}, {1'b1, 37'hB1});
        tick;

        // Backpressure and full boundary
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_valid = 1'b1;
            a_addr  = W'(32'h10 + i);
            tick;
            if (i == 3) chk("bp_ready_cnt3", a_ready, 1);
            if (i == 4) chk("bp_ready_full", a_ready, 0);
        end
        a_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("bp_hold_addr", out_addr, 37'h10);
            chk("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        tick;
        chk("full_pop_ready", a_ready, 1);
        chk("full_pop_addr", out_addr, 37'h11);
        a_valid = 1'b1;
        a_addr  = 37'h15;
        tick;
        chk("pushpop_addr", out_addr, 37'h12);
        chk("pushpop_ready", a_ready, 1);
        out_ready = 1'b0;
        a_addr    = 37'h16;
        tick;
        chk("pushpop_cnt_was3", a_ready, 0);
        a_valid   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("bp_drain", out_addr, 32'h13 + i);
        end
        tick;
        chk("bp_idle", out_valid, 0);

        // Mid-operation reset with both FIFOs partly filled
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_addr = W'(32'h30 + i);
            b_valid = 1'b1; b_addr = W'(32'h40 + i);
            tick;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n   = 1'b0;
        tick;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_a_ready", a_ready, 1);
        chk("midrst_b_ready", b_ready, 1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("midrst_stays_idle", out_valid, 0);
        end

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            a_valid = ($urandom_range(0, 99) < 60);
            b_valid = ($urandom_range(0, 99) < 45);
            r = {$urandom(), $urandom()};
            a_addr = r[W-1:0];
            r = {$urandom(), $urandom()};
            b_addr = r[W-1:0];
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 599) != 0);
            tick;
        end
        rst_n   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick;
        chk("final_idle", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
